// File: rtl/pov_column_reader.sv
// rtl/pov_column_reader.sv - fetches one 16-bit column per col_tick from ROM and
// shifts it MSB-first into a latched LED driver, tracking the column position.
`timescale 1ns/1ps
module pov_column_reader #(
   parameter int          NUM_COLS  = 128,
   parameter logic [10:0] BASE_ADDR = 11'd0,
   parameter int          SCLK_DIV  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        col_tick,
   input  logic        frame_sync,
   output logic        leer_rom,
   output logic [10:0] dir_rom,
   input  logic [15:0] dato_rom,
   output logic        led_sdo,
   output logic        led_sclk,
   output logic        led_latch,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);
   localparam int             DW       = (SCLK_DIV < 2) ? 1 : $clog2(SCLK_DIV);
   localparam logic [DW-1:0]  CNT_LAST = DW'(SCLK_DIV - 1);
   localparam logic [10:0]    COL_LAST = 11'(NUM_COLS - 1);

   typedef enum logic [2:0] {IDLE, REQ, CAPT, SHIFT, LATCH} state_t;

   state_t         r_state, w_state;
   logic [10:0]    r_col, w_col;
   logic           r_pend, w_pend;
   logic [15:0]    r_sr, w_sr;
   logic [DW-1:0]  r_cnt, w_cnt;
   logic [3:0]     r_bit, w_bit;
   logic           r_leer, w_leer;
   logic [10:0]    r_dir, w_dir;
   logic           r_sdo, w_sdo;
   logic           r_sclk, w_sclk;
   logic           r_latch, w_latch;
   logic           r_busy, w_busy;
   logic           r_fdone, w_fdone;
   logic           r_ovr, w_ovr;
   logic           w_cnt_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_col   <= '0;
         r_pend  <= 1'b0;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_leer  <= 1'b0;
         r_dir   <= '0;
         r_sdo   <= 1'b0;
         r_sclk  <= 1'b0;
         r_latch <= 1'b0;
         r_busy  <= 1'b0;
         r_fdone <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_col   <= w_col;
         r_pend  <= w_pend;
         r_sr    <= w_sr;
         r_cnt   <= w_cnt;
         r_bit   <= w_bit;
         r_leer  <= w_leer;
         r_dir   <= w_dir;
         r_sdo   <= w_sdo;
         r_sclk  <= w_sclk;
         r_latch <= w_latch;
         r_busy  <= w_busy;
         r_fdone <= w_fdone;
         r_ovr   <= w_ovr;
      end
   end

   // Every output is computed for the next state and registered alongside it.
   always_comb begin
      w_state   = r_state;
      w_col     = r_col;
      w_pend    = r_pend;
      w_sr      = r_sr;
      w_cnt     = r_cnt;
      w_bit     = r_bit;
      w_leer    = 1'b0;
      w_dir     = r_dir;
      w_sdo     = r_sdo;
      w_sclk    = r_sclk;
      w_latch   = r_latch;
      w_busy    = r_busy;
      w_fdone   = 1'b0;
      w_ovr     = col_tick && (r_state != IDLE);
      w_cnt_end = (r_cnt == CNT_LAST);
      if (frame_sync && (r_state != IDLE)) w_pend = 1'b1;

      case (r_state)
         IDLE: begin
            if (frame_sync) w_col = '0;
            if (col_tick) begin
               w_state = REQ;
               w_busy  = 1'b1;
               w_leer  = 1'b1;
               w_dir   = BASE_ADDR + (frame_sync ? 11'd0 : r_col);
            end
         end
         REQ: w_state = CAPT;
         CAPT: begin
            w_state = SHIFT;
            w_sr    = dato_rom;
            w_sdo   = dato_rom[15];
            w_sclk  = 1'b0;
            w_cnt   = '0;
            w_bit   = '0;
         end
         SHIFT: begin
            if (!w_cnt_end) begin
               w_cnt = r_cnt + 1'b1;
            end else begin
               w_cnt = '0;
               if (!r_sclk) begin
                  w_sclk = 1'b1;
               end else if (r_bit == 4'd15) begin
                  w_state = LATCH;
                  w_sclk  = 1'b0;
                  w_latch = 1'b1;
                  w_sdo   = 1'b0;
               end else begin
                  w_sclk = 1'b0;
                  w_bit  = r_bit + 4'd1;
                  w_sr   = {r_sr[14:0], 1'b0};
                  w_sdo  = r_sr[14];
               end
            end
         end
         LATCH: begin
            if (!w_cnt_end) begin
               w_cnt = r_cnt + 1'b1;
            end else begin
               w_cnt   = '0;
               w_state = IDLE;
               w_latch = 1'b0;
               w_busy  = 1'b0;
               // A restart requested mid-transfer wins over the wrap and is silent.
               if (r_pend || frame_sync) begin
                  w_col  = '0;
                  w_pend = 1'b0;
               end else if (r_col == COL_LAST) begin
                  w_col   = '0;
                  w_fdone = 1'b1;
               end else begin
                  w_col = r_col + 11'd1;
               end
            end
         end
         default: w_state = IDLE;
      endcase
   end

   assign leer_rom   = r_leer;
   assign dir_rom    = r_dir;
   assign led_sdo    = r_sdo;
   assign led_sclk   = r_sclk;
   assign led_latch  = r_latch;
   assign busy       = r_busy;
   assign frame_done = r_fdone;
   assign overrun    = r_ovr;
endmodule
